// File: rtl/led_scan_ctrl_if.sv
// ============================================================================
//  Module      : led_scan_ctrl_if
//  Description : Frame-update handshake between a BCD frame producer and the
//                LED scan controller.
//                  upd_req  producer -> controller  new frame request
//                  upd_val  producer -> controller  8 BCD digits, digit 0 = [31:28]
//                  upd_ack  controller -> producer  one-cycle capture pulse
//                Modports: master (frame producer), slave (scan controller).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_scan_ctrl_if;
  logic        upd_req;
  logic [31:0] upd_val;
  logic        upd_ack;

  modport master (
    output upd_req,
    output upd_val,
    input  upd_ack
  );

  modport slave (
    input  upd_req,
    input  upd_val,
    output upd_ack
  );
endinterface

`default_nettype wire

// File: rtl/led_scan_ctrl.sv
// ============================================================================
//  Module      : led_scan_ctrl
//  Description : Time-multiplexed scan controller for an 8-digit common-bus
//                7-segment display. Each digit slot is a blanking gap of
//                BLANK_CYC cycles followed by DRIVE_CYC cycles with the digit
//                lit. New frames are accepted only at the frame boundary (end
//                of digit 7's drive phase) so a frame never mixes old and new
//                digits.
//  Ports       : clk         in   system clock
//                RSTn        in   asynchronous active-low reset
//                upd         slave modport of led_scan_ctrl_if
//                            (upd_req/upd_val in, upd_ack out)
//                seg         out  segment byte {a,b,c,d,e,f,g,dp}, active-high
//                dig_en      out  one-hot digit enable, bit i = digit i
//                frame_done  out  one-cycle pulse at each frame boundary
//  Parameters  : BLANK_CYC  cycles per slot with all digits off (>=1)
//                DRIVE_CYC  cycles per slot with the digit lit (>=1)
//  Options     : LED_LZB_EN  when defined, enables leading-zero blanking:
//                digit i (0..6) is dark while digits 0..i of the active
//                frame are all zero; digit 7 is always decoded.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_scan_ctrl #(
  parameter int BLANK_CYC = 4,
  parameter int DRIVE_CYC = 60
) (
  input  wire logic       clk,
  input  wire logic       RSTn,
  led_scan_ctrl_if.slave  upd,
  output logic [7:0]      seg,
  output logic [7:0]      dig_en,
  output logic            frame_done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_cnt_max = (BLANK_CYC > DRIVE_CYC) ? BLANK_CYC : DRIVE_CYC;
  // Keep at least one bit so a 1-cycle/1-cycle configuration still elaborates.
  localparam int c_cw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYC - 1);
  localparam logic [c_cw-1:0] c_drive_last = c_cw'(DRIVE_CYC - 1);
  localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
  localparam logic [2:0]      c_idx_one    = 3'd1;
  localparam logic [2:0]      c_idx_last   = 3'd7;

  localparam logic [0:0] S_BLANK = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  logic [0:0]      r_state;
  logic [2:0]      r_idx;
  logic [c_cw-1:0] r_cnt;
  logic [31:0]     r_active;
  logic [7:0]      r_seg;
  logic [7:0]      r_dig_en;
  logic            r_frame_done;
  logic            r_upd_ack;

  logic [0:0]      w_state_nxt;
  logic [2:0]      w_idx_nxt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic            w_frame_end;

  logic [7:0]      w_seg_nxt;
  logic [7:0]      w_dig_nxt;
  logic            w_fd_nxt;
  logic            w_ack_nxt;

  logic [7:0]      w_digit_seg [8];

  // --------------------------------------------------------------------------
  // BCD to segment decode; A..E show a dash, F is blank, dp is never lit.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_decode(input logic [3:0] bcd);
    logic [7:0] s;
    case (bcd)
      4'h0:    s = 8'hFC;
      4'h1:    s = 8'h60;
      4'h2:    s = 8'hDA;
      4'h3:    s = 8'hF2;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'hB6;
      4'h6:    s = 8'hBE;
      4'h7:    s = 8'hE0;
      4'h8:    s = 8'hFE;
      4'h9:    s = 8'hF6;
      4'hF:    s = 8'h00;
      default: s = 8'h02;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Per-digit segment pattern, derived from the active frame only.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 8; i++) begin : g_digit
    logic [3:0] w_bcd;
    assign w_bcd = r_active[31-4*i -: 4];
`ifdef LED_LZB_EN
    if (i < 7) begin : g_lzb
      // Dark while this digit and every more-significant one are zero.
      assign w_digit_seg[i] = (~|r_active[31 -: 4*(i+1)]) ? 8'h00 : f_decode(w_bcd);
    end else begin : g_last
      // The least-significant digit always shows, so an all-zero frame reads "0".
      assign w_digit_seg[i] = f_decode(w_bcd);
    end
`else
    assign w_digit_seg[i] = f_decode(w_bcd);
`endif
  end

  // --------------------------------------------------------------------------
  // State register (also holds the registered outputs and the active frame)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= 32'hFFFF_FFFF;
      r_seg        <= '0;
      r_dig_en     <= '0;
      r_frame_done <= 1'b0;
      r_upd_ack    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_seg        <= w_seg_nxt;
      r_dig_en     <= w_dig_nxt;
      r_frame_done <= w_fd_nxt;
      r_upd_ack    <= w_ack_nxt;
      // Capture only at the frame boundary; digit 0 of the new frame is
      // decoded from this value when its drive phase starts.
      if (w_ack_nxt) begin
        r_active <= upd.upd_val;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: slot counter runs 0..N-1 within each phase.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + c_cnt_one;
    w_frame_end = 1'b0;
    case (r_state)
      S_BLANK: begin
        if (r_cnt == c_blank_last) begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == c_drive_last) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + c_idx_one;
          w_frame_end = (r_idx == c_idx_last);
        end
      end
      default: begin
        w_state_nxt = S_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: computed from the next state so the registered outputs line
  // up with the state they describe (dig_en rises exactly BLANK_CYC clocks
  // after reset release).
  // --------------------------------------------------------------------------
  always_comb begin
    w_seg_nxt = 8'h00;
    w_dig_nxt = 8'h00;
    if (w_state_nxt == S_DRIVE) begin
      w_dig_nxt = 8'h01 << w_idx_nxt;
      w_seg_nxt = w_digit_seg[w_idx_nxt];
    end
    w_fd_nxt  = w_frame_end;
    w_ack_nxt = w_frame_end & upd.upd_req;
  end

  assign seg         = r_seg;
  assign dig_en      = r_dig_en;
  assign frame_done  = r_frame_done;
  assign upd.upd_ack = r_upd_ack;

endmodule

`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
// ============================================================================
//  Module      : tb_led_scan_ctrl
//  Description : Self-checking bench for led_scan_ctrl (BLANK_CYC=2,
//                DRIVE_CYC=4). A scoreboard queue holds the expected
//                {dig_en, seg} of every digit slot; a monitor pops one entry
//                per lit slot and also checks slot timing, frame length and
//                the ack/frame_done relationship.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_scan_ctrl;

  localparam int BLANK_CYC = 2;
  localparam int DRIVE_CYC = 4;
  localparam int FRAME_CYC = 8 * (BLANK_CYC + DRIVE_CYC);

  logic       clk = 1'b0;
  logic       RSTn;
  logic [7:0] seg;
  logic [7:0] dig_en;
  logic       frame_done;

  led_scan_ctrl_if upd ();

  led_scan_ctrl #(
    .BLANK_CYC (BLANK_CYC),
    .DRIVE_CYC (DRIVE_CYC)
  ) dut (
    .clk        (clk),
    .RSTn       (RSTn),
    .upd        (upd),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q [$];
  logic [31:0] model_frame;
  logic [31:0] drv_val;
  bit          mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the segment table.
  function automatic logic [7:0] model_seg(input logic [31:0] f, input int i);
    logic [3:0] d;
    logic [7:0] s;
    bit         allz;
    d = f[31-4*i -: 4];
    case (d)
      4'h0: s = 8'hFC;  4'h1: s = 8'h60;  4'h2: s = 8'hDA;  4'h3: s = 8'hF2;
      4'h4: s = 8'h66;  4'h5: s = 8'hB6;  4'h6: s = 8'hBE;  4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;  4'h9: s = 8'hF6;  4'hF: s = 8'h00;
      default: s = 8'h02;
    endcase
    allz = 1'b1;
    for (int k = 0; k <= i; k++)
      if (f[31-4*k -: 4] != 4'h0) allz = 1'b0;
`ifdef LED_LZB_EN
    if (i < 7 && allz) s = 8'h00;
`endif
    return s;
  endfunction

  task automatic push_frame(input logic [31:0] f);
    logic [7:0] oh;
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      exp_q.push_back({oh, model_seg(f, i)});
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [7:0]  prev_dig;
  logic [15:0] cur;
  int          blank_len, drive_len, cyc, last_fd;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_dig  = 8'h00;
      cur       = 16'h0;
      blank_len = 0;
      drive_len = 0;
      cyc       = 0;
      last_fd   = -1;
    end else begin
      cyc++;
      if (dig_en != 8'h00) begin
        if (prev_dig == 8'h00) begin
          check_val("gap_len", blank_len, BLANK_CYC);
          if (exp_q.size() == 0) begin
            check_val("slot_unexpected", dig_en, 8'h00);
            cur = 16'h0;
          end else begin
            cur = exp_q.pop_front();
          end
          drive_len = 0;
        end
        drive_len++;
        blank_len = 0;
        check_val("dig_en", dig_en, cur[15:8]);
        check_val("seg", seg, cur[7:0]);
      end else begin
        if (prev_dig != 8'h00) check_val("drive_len", drive_len, DRIVE_CYC);
        blank_len++;
        check_val("seg_blank", seg, 8'h00);
      end
      if (frame_done) begin
        check_val("fd_after_d7", prev_dig, 8'h80);
        if (last_fd >= 0) check_val("frame_len", cyc - last_fd, FRAME_CYC);
        last_fd = cyc;
        if (upd.upd_ack) model_frame = drv_val;
        push_frame(model_frame);
      end
      if (upd.upd_ack) check_val("ack_with_fd", frame_done, 1'b1);
      prev_dig = dig_en;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic wait_dig(input logic [7:0] v, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dig_en != v && n < maxc);
    if (dig_en != v) check_val("wait_dig_timeout", dig_en, v);
  endtask

  task automatic wait_fd(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < maxc);
    if (!frame_done) check_val("wait_fd_timeout", frame_done, 1'b1);
  endtask

  // Raises the request at the current negedge, drops it the cycle after ack.
  task automatic request(input logic [31:0] v, output int lat);
    lat = 0;
    drv_val         = v;
    upd.upd_val     = v;
    upd.upd_req     = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!upd.upd_ack && lat < 3 * FRAME_CYC);
    if (!upd.upd_ack) check_val("ack_timeout", upd.upd_ack, 1'b1);
    upd.upd_req = 1'b0;
  endtask

  task automatic release_reset();
    int n = 0;
    @(posedge clk);
    #1;
    RSTn = 1'b1;
    exp_q.delete();
    model_frame = 32'hFFFF_FFFF;
    push_frame(model_frame);
    mon_en = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (dig_en != 8'h01 && n < 10);
    check_val("first_lit_clks", n, BLANK_CYC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    RSTn        = 1'b0;
    upd.upd_req = 1'b0;
    upd.upd_val = 32'h0;
    drv_val     = 32'h0;
    model_frame = 32'hFFFF_FFFF;

    // Reset state, with a request pending to show it is ignored.
    upd.upd_req = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_seg", seg, 8'h00);
    check_val("rst_dig_en", dig_en, 8'h00);
    check_val("rst_fd", frame_done, 1'b0);
    check_val("rst_ack", upd.upd_ack, 1'b0);
    upd.upd_req = 1'b0;

    release_reset();
    wait_fd(FRAME_CYC + 10);
    wait_fd(FRAME_CYC + 10);

    // Request right after a boundary waits a full frame.
    request(32'h1234_5678, lat);
    check_val("ack_lat_full", lat, FRAME_CYC);
    wait_fd(FRAME_CYC + 10);

    // Request during digit 3: digits 3..7 keep the old frame.
    wait_dig(8'h08, FRAME_CYC + 10);
    request(32'hABCD_EF90, lat);
    check_val("ack_lat_mid", lat, 28);
    wait_fd(FRAME_CYC + 10);

    request(32'h0000_0305, lat);
    wait_fd(FRAME_CYC + 10);

    // Reset at digit 5 with a request pending.
    wait_dig(8'h08, FRAME_CYC + 10);
    drv_val     = 32'h1111_1111;
    upd.upd_val = 32'h1111_1111;
    upd.upd_req = 1'b1;
    wait_dig(8'h20, FRAME_CYC + 10);
    #1;
    RSTn   = 1'b0;
    mon_en = 1'b0;
    #1;
    check_val("midrst_seg", seg, 8'h00);
    check_val("midrst_dig_en", dig_en, 8'h00);
    check_val("midrst_fd", frame_done, 1'b0);
    check_val("midrst_ack", upd.upd_ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_hold_ack", upd.upd_ack, 1'b0);
    end
    upd.upd_req = 1'b0;
    release_reset();
    wait_fd(FRAME_CYC + 10);
    wait_fd(FRAME_CYC + 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
